// File: rtl/mem_stage.sv
// mem_stage -- memory stage of the 5-stage RV32I pipeline.
//
// Holds the E->M pipeline register and drives the data-memory bus. A load or
// store that enters M raises dmem_req and keeps it raised until dmem_ready.
// Load data is sign/zero-extended on the way to the M->W register. Store data
// is replicated across byte lanes and byte enables are generated.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   *E inputs                instruction leaving the execute stage
//   FlushM                   turn the instruction entering M into a bubble
//   dmem_req/we/addr/wdata/be  data bus request side (addr is word aligned)
//   dmem_rdata, dmem_ready   data bus response side
//   MemStallM                hold F/D/E and this stage while an access waits
//   *M outputs               to the M->W pipeline register
//   MisalignM                (MEM_MISALIGN_TRAP_EN only) misaligned access flag
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned LH/SH/LW/SW never reach the bus and raise MisalignM
//   undefined -> the low address bits are ignored for halfword/word accesses

module mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteE,
   input  logic [1:0]            ResultSrcE,
   input  logic                  MemWriteE,
   input  logic                  MemReadE,
   input  logic [2:0]            funct3E,
   input  logic [31:0]           ALUResultE,
   input  logic [DATA_WIDTH-1:0] WriteDataE,
   input  logic [4:0]            RdE,
   input  logic [31:0]           PCPlus4E,
   input  logic                  FlushM,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   input  logic                  dmem_ready,
   output logic                  MemStallM,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic                  MisalignM,
`endif
   output logic                  RegWriteM,
   output logic [1:0]            ResultSrcM,
   output logic [31:0]           ALUResultM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic [4:0]            RdM,
   output logic [31:0]           PCPlus4M
);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t                state_q, state_d;
   logic                  regwrite_q, memwrite_q, memread_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] writedata_q;
   logic                  mem_op_e;
   logic [3:0]            be_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic [DATA_WIDTH-1:0] rdata_ext;
   logic                  misalign_m;

`ifdef MEM_MISALIGN_TRAP_EN
   // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always fine.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b01:   is_misaligned = a[0];
         2'b10:   is_misaligned = (a != 2'b00);
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   assign mem_op_e   = (MemReadE | MemWriteE) & ~FlushM
                       & ~is_misaligned(funct3E[1:0], ALUResultE[1:0]);
   assign misalign_m = (memread_q | memwrite_q)
                       & is_misaligned(funct3_q[1:0], ALUResultM[1:0]);
   assign MisalignM  = misalign_m;
`else
   assign mem_op_e   = (MemReadE | MemWriteE) & ~FlushM;
   assign misalign_m = 1'b0;
`endif

   // E->M register. It only moves when the stage is not stalled, so an
   // outstanding access keeps its address and data stable, and a flush that
   // arrives during a stall is ignored. A flush loads an all-zero bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_q  <= 1'b0;
         ResultSrcM  <= 2'b00;
         memwrite_q  <= 1'b0;
         memread_q   <= 1'b0;
         funct3_q    <= 3'b000;
         ALUResultM  <= '0;
         writedata_q <= '0;
         RdM         <= '0;
         PCPlus4M    <= '0;
      end else if (!MemStallM) begin
         if (FlushM) begin
            regwrite_q  <= 1'b0;
            ResultSrcM  <= 2'b00;
            memwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            funct3_q    <= 3'b000;
            ALUResultM  <= '0;
            writedata_q <= '0;
            RdM         <= '0;
            PCPlus4M    <= '0;
         end else begin
            regwrite_q  <= RegWriteE;
            ResultSrcM  <= ResultSrcE;
            memwrite_q  <= MemWriteE;
            memread_q   <= MemReadE;
            funct3_q    <= funct3E;
            ALUResultM  <= ALUResultE;
            writedata_q <= WriteDataE;
            RdM         <= RdE;
            PCPlus4M    <= PCPlus4E;
         end
      end
   end

   // Access state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Whenever the register captures a new instruction (no stall), the next
   // state is decided by that instruction alone. This gives back-to-back
   // accesses with no idle cycle in between: a memory op captured on the
   // ready edge keeps the FSM in ACCESS.
   always_comb begin
      state_d = state_q;
      if (!MemStallM) state_d = mem_op_e ? S_ACCESS : S_IDLE;
   end

   assign MemStallM = (state_q == S_ACCESS) & ~dmem_ready;

   // Store lane placement and byte enables. Loads read the whole word and
   // pick their lanes on the way back.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = writedata_q;
      if (memwrite_q) begin
         case (funct3_q[1:0])
            2'b00: begin
               be_c    = 4'b0001 << ALUResultM[1:0];
               wdata_c = {4{writedata_q[7:0]}};
            end
            2'b01: begin
               be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
               wdata_c = {2{writedata_q[15:0]}};
            end
            default: begin
               be_c    = 4'b1111;
               wdata_c = writedata_q;
            end
         endcase
      end
   end

   // Load lane selection and extension. funct3[2] selects zero extension.
   always_comb begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel  = 8'h00;
      half_sel  = 16'h0000;
      rdata_ext = dmem_rdata;
      case (ALUResultM[1:0])
         2'b00:   byte_sel = dmem_rdata[7:0];
         2'b01:   byte_sel = dmem_rdata[15:8];
         2'b10:   byte_sel = dmem_rdata[23:16];
         default: byte_sel = dmem_rdata[31:24];
      endcase
      half_sel = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   rdata_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
         2'b01:   rdata_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
         default: rdata_ext = dmem_rdata;
      endcase
   end

   // Bus outputs are driven only while an access is in flight, so they are
   // zero when idle and constant for the whole ACCESS period.
   assign dmem_req   = (state_q == S_ACCESS);
   assign dmem_we    = dmem_req & memwrite_q;
   assign dmem_addr  = dmem_req ? {ALUResultM[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign dmem_wdata = dmem_req ? wdata_c : '0;
   assign dmem_be    = dmem_req ? be_c : 4'b0000;

   assign ReadDataM  = (memread_q & ~misalign_m) ? rdata_ext : '0;
   assign RegWriteM  = regwrite_q & ~MemStallM & ~misalign_m;

endmodule
